// File: rtl/vrf_pkg.sv
// Shared types and helpers for the vector register file (vector_rf).
package vrf_pkg;

    // Bulk-clear engine states
    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_t;

    // LSB position of lane `lane` of port `port` inside a flat multi-port,
    // multi-lane bus laid out port-major, lane-minor.
    function automatic int lane_lsb(input int port, input int lane,
                                    input int lanes, input int width);
        return (port * lanes + lane) * width;
    endfunction

endpackage

// File: rtl/vrf_read_port.sv
// One combinational read port of vector_rf: address mux, out-of-range and
// register-0 zeroing, plus the optional same-cycle write bypass
// (compiled in when VRF_BYPASS_EN is defined).
module vrf_read_port
    import vrf_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int LANES   = 4,
    parameter  int NREGS   = 32,
    parameter  int ZERO_R0 = 0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic [LANES-1:0][WIDTH-1:0] i_regs [NREGS],
    input  logic [AW-1:0]               i_rs,
`ifdef VRF_BYPASS_EN
    input  logic                        i_wr_en,
    input  logic [AW-1:0]               i_wr_addr,
    input  logic [LANES-1:0][WIDTH-1:0] i_wd,
    input  logic [LANES-1:0]            i_wmask,
`endif
    output logic [LANES-1:0][WIDTH-1:0] o_rdv
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic w_addr_ok;

    assign w_addr_ok = ({1'b0, i_rs} < NREGS_W) && !((ZERO_R0 != 0) && (i_rs == '0));

    // Select the addressed register; zeroing of r0/out-of-range wins over bypass
    always_comb begin
        // NOTE: default first so every path assigns o_rdv and no latch is inferred.
        o_rdv = '0;
        if (w_addr_ok) begin
            o_rdv = i_regs[i_rs];
`ifdef VRF_BYPASS_EN
            for (int l = 0; l < LANES; l++) begin
                if (i_wr_en && (i_wr_addr == i_rs) && i_wmask[l]) begin
                    o_rdv[l] = i_wd[l];
                end
            end
`endif
        end
    end

endmodule

// File: rtl/vector_rf.sv
// vector_rf: NREGS x (LANES x WIDTH) register file with NREAD combinational
// read ports, one lane-masked write port and a one-register-per-cycle bulk
// clear engine with busy/done handshake.
// Optional feature macro: VRF_BYPASS_EN (same-cycle write-to-read bypass).
module vector_rf
    import vrf_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int LANES   = 4,
    parameter  int NREGS   = 32,
    parameter  int NREAD   = 3,
    parameter  int ZERO_R0 = 0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREAD*AW-1:0]            RS,
    output logic [NREAD*LANES*WIDTH-1:0]   RDV,
    input  logic [AW-1:0]                  RD,
    input  logic [LANES*WIDTH-1:0]         WD,
    input  logic [LANES-1:0]               WMASK,
    input  logic                           WEV,
    input  logic                           CLR_REQ,
    output logic                           CLR_BUSY,
    output logic                           CLR_DONE
);

    localparam logic [AW:0] NREGS_W  = (AW+1)'(NREGS);
    localparam logic [AW:0] LAST_PTR = (AW+1)'(NREGS - 1);

    // The port CLR_DONE shadows the enum literal of the same name, so the
    // state literals are always written package-qualified in this module.
    clr_state_t                  r_state;
    clr_state_t                  w_state_next;
    logic [AW:0]                 r_ptr;
    logic [LANES-1:0][WIDTH-1:0] r_regs [NREGS];
    logic [LANES-1:0][WIDTH-1:0] w_wd;
    logic                        w_wr_accept;

    assign w_wd = WD;

    // A write lands only outside a clear, to an existing, writable register
    assign w_wr_accept = WEV && !CLR_BUSY && ({1'b0, RD} < NREGS_W)
                         && !((ZERO_R0 != 0) && (RD == '0));

    // Clear FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_state <= vrf_pkg::CLR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            vrf_pkg::CLR_IDLE: if (CLR_REQ) w_state_next = vrf_pkg::CLR_RUN;
            vrf_pkg::CLR_RUN:  if (r_ptr == LAST_PTR) w_state_next = vrf_pkg::CLR_DONE;
            vrf_pkg::CLR_DONE: w_state_next = vrf_pkg::CLR_IDLE;
            default:           w_state_next = vrf_pkg::CLR_IDLE;
        endcase
    end

    // Clear FSM outputs
    always_comb begin
        CLR_BUSY = 1'b0;
        CLR_DONE = 1'b0;
        unique case (r_state)
            vrf_pkg::CLR_RUN:  CLR_BUSY = 1'b1;
            vrf_pkg::CLR_DONE: CLR_DONE = 1'b1;
            default: ;
        endcase
    end

    // Clear pointer: restarts on an accepted request, walks 0..NREGS-1, never wraps
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else begin
            unique case (r_state)
                vrf_pkg::CLR_IDLE: if (CLR_REQ) r_ptr <= '0;
                vrf_pkg::CLR_RUN:  if (r_ptr != LAST_PTR) r_ptr <= r_ptr + 1'b1;
                default: ;
            endcase
        end
    end

    // Register array: reset clear, bulk-clear step, or lane-masked write
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: this array is reset on purpose (reset must read back as zero), which keeps it in flops rather than RAM.
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == vrf_pkg::CLR_RUN) begin
            r_regs[r_ptr[AW-1:0]] <= '0;
        end else if (w_wr_accept) begin
            for (int l = 0; l < LANES; l++) begin
                if (WMASK[l]) begin
                    r_regs[RD][l] <= w_wd[l];
                end
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [LANES-1:0][WIDTH-1:0] w_rdv;

        vrf_read_port #(
            .WIDTH   (WIDTH),
            .LANES   (LANES),
            .NREGS   (NREGS),
            .ZERO_R0 (ZERO_R0)
        ) u_read_port (
            .i_regs    (r_regs),
            .i_rs      (RS[p*AW +: AW]),
`ifdef VRF_BYPASS_EN
            .i_wr_en   (w_wr_accept),
            .i_wr_addr (RD),
            .i_wd      (w_wd),
            .i_wmask   (WMASK),
`endif
            .o_rdv     (w_rdv)
        );

        assign RDV[lane_lsb(p, 0, LANES, WIDTH) +: LANES*WIDTH] = w_rdv;
    end

endmodule
